// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding,
// default memory depth, and the registered status/strobe bundle.
// No logic beyond a pure state->flags decode used at state transitions.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_t;

  localparam int IMEM_WORDS_DEFAULT = 64;

  // Registered outputs that are a pure function of the state being entered.
  typedef struct packed {
    logic in_ready;
    logic mem_we;
    logic busy;
    logic cpu_reset;
    logic done;
    logic error;
  } loader_flags_t;

  // Output flags to load alongside the next state, so every output comes
  // straight from a flop rather than from a decode of the state register.
  function automatic loader_flags_t state_flags(input loader_state_t s);
    loader_flags_t f;
    f = '0;
    case (s)
      HDR:   begin f.in_ready = 1'b1; f.busy = 1'b1; f.cpu_reset = 1'b1; end
      DATA:  begin f.in_ready = 1'b1; f.busy = 1'b1; f.cpu_reset = 1'b1; end
      WRITE: begin f.mem_we   = 1'b1; f.busy = 1'b1; f.cpu_reset = 1'b1; end
      DONE:  begin f.done     = 1'b1; end
      ERR:   begin f.error    = 1'b1; f.cpu_reset = 1'b1; end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a byte image (1-byte word count header, then little-endian words) into imem.
// Latency: mem_we asserts the cycle after the 4th byte of a word is accepted; 1 word / 5 cycles peak.
// Backpressure: in_ready low outside HDR/DATA (including the single WRITE cycle); in_valid may stall freely.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  words_loaded
);

  // Header values above this are larger than the target memory.
  localparam logic [8:0] MAX_WORDS = 9'(MEM_WORDS);

  loader_state_t state;
  loader_flags_t flags;
  logic [1:0]    byte_cnt;
  logic [23:0]   shift;     // bytes 0..2 of the word being assembled
  logic [7:0]    n_words;   // word count from the header
  logic          accept;
  logic          hdr_bad;
  logic [31:0]   packed_word;
  logic [7:0]    words_next;

  assign accept      = in_valid && flags.in_ready;
  assign hdr_bad     = (in_data == 8'd0) || ({1'b0, in_data} > MAX_WORDS);
  // Newest byte enters at the top, so after 4 bytes the first one sits in [7:0].
  assign packed_word = {in_data, shift};
  assign words_next  = words_loaded + 8'd1;

  assign in_ready  = flags.in_ready;
  assign mem_we    = flags.mem_we;
  assign busy      = flags.busy;
  assign cpu_reset = flags.cpu_reset;
  assign done      = flags.done;
  assign error     = flags.error;

  // Load-session FSM with byte packer; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      flags        <= '0;
      byte_cnt     <= '0;
      shift        <= '0;
      n_words      <= '0;
      mem_addr     <= '0;
      mem_wd       <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            flags        <= state_flags(HDR);
            words_loaded <= '0;
            byte_cnt     <= '0;
          end
        end

        HDR: begin
          if (accept) begin
            n_words <= in_data;
            if (hdr_bad) begin
              state <= ERR;
              flags <= state_flags(ERR);
            end else begin
              state <= DATA;
              flags <= state_flags(DATA);
            end
          end
        end

        DATA: begin
          if (accept) begin
            shift    <= packed_word[31:8];
            byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 ready for the next word
            if (byte_cnt == 2'd3) begin
              state    <= WRITE;
              flags    <= state_flags(WRITE);
              mem_addr <= {22'd0, words_loaded, 2'b00};
              mem_wd   <= packed_word;
            end
          end
        end

        WRITE: begin
          words_loaded <= words_next;
          if (words_next == n_words) begin
            state <= DONE;
            flags <= state_flags(DONE);
          end else begin
            state <= DATA;
            flags <= state_flags(DATA);
          end
        end

        default: begin
          state <= IDLE;
          flags <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  imem_loader #(.MEM_WORDS(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wd);
    end
  end

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte, optionally after idle cycles; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int stall);
    int waited;
    in_valid = 1'b0;
    repeat (stall) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL byte_accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  // Send a word LSB first; mem_we must appear exactly after the 4th byte.
  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input int max_stall);
    for (int j = 0; j < 4; j++) begin
      send_byte(w[8*j +: 8], (max_stall > 0) ? $urandom_range(0, max_stall) : 0);
      checks++;
      if (j < 3 && mem_we !== 1'b0) begin
        errors++;
        $display("FAIL early_write: mem_we=%b after byte %0d required 0", mem_we, j);
      end
    end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== addr || mem_wd !== w) begin
      errors++;
      $display("FAIL write_strobe: we=%b addr=%h wd=%h required we=1 addr=%h wd=%h",
               mem_we, mem_addr, mem_wd, addr, w);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, cpu_reset, busy, done, error} !== 6'b0 ||
        mem_addr !== 32'h0 || mem_wd !== 32'h0 || words_loaded !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b we=%b cpu_rst=%b busy=%b done=%b err=%b addr=%h wd=%h wl=%0d required all 0",
               in_ready, mem_we, cpu_reset, busy, done, error, mem_addr, mem_wd, words_loaded);
    end
  endtask

  task automatic test_basic_load(input int max_stall, input string name);
    clear_writes();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_hdr_state: busy=%b cpu_rst=%b rdy=%b required 1 1 1", name, busy, cpu_reset, in_ready);
    end
    send_byte(8'h02, max_stall);
    send_word(32'h12345678, 32'h0, max_stall);
    send_word(32'hDEADBEEF, 32'h4, max_stall);
    wait_done();
    checks++;
    if (words_loaded !== 8'd2 || cpu_reset !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: wl=%0d cpu_rst=%b busy=%b err=%b required 2 0 0 0", name, words_loaded, cpu_reset, busy, error);
    end
    checks++;
    if (wq_addr.size() != 2) begin
      errors++;
      $display("FAIL %s_write_count: %0d writes required 2", name, wq_addr.size());
    end else if (wq_addr[0] !== 32'h0 || wq_data[0] !== 32'h12345678 ||
                 wq_addr[1] !== 32'h4 || wq_data[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL %s_write_log: %h@%h %h@%h required 12345678@0 deadbeef@4",
               name, wq_data[0], wq_addr[0], wq_data[1], wq_addr[1]);
    end
  endtask

  task automatic test_bad_header();
    clear_writes();
    pulse_start();
    send_byte(8'h00, 0);
    checks++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hdr_zero: err=%b cpu_rst=%b rdy=%b busy=%b done=%b required 1 1 0 0 0",
               error, cpu_reset, in_ready, busy, done);
    end
    repeat (3) @(negedge clk);
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clears_error: err=%b busy=%b required 0 1", error, busy);
    end
    send_byte(8'h41, 0);
    checks++;
    if (error !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL hdr_too_big: err=%b cpu_rst=%b required 1 1", error, cpu_reset);
    end
    checks++;
    if (wq_addr.size() != 0) begin
      errors++;
      $display("FAIL err_no_write: %0d writes required 0", wq_addr.size());
    end
    pulse_start();
    send_byte(8'h01, 0);
    send_word(32'hCAFEF00D, 32'h0, 0);
    wait_done();
    checks++;
    if (error !== 1'b0 || cpu_reset !== 1'b0 || words_loaded !== 8'd1) begin
      errors++;
      $display("FAIL recover_after_err: err=%b cpu_rst=%b wl=%0d required 0 0 1", error, cpu_reset, words_loaded);
    end
  endtask

  task automatic test_full_depth();
    logic [31:0] w;
    int bad;
    clear_writes();
    pulse_start();
    send_byte(8'h40, 0);
    for (int k = 0; k < 64; k++) begin
      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      send_word(w, 32'(4*k), 0);
      if (k == 10) begin
        pulse_start();   // must be ignored while busy
        checks++;
        if (busy !== 1'b1 || words_loaded !== 8'd11) begin
          errors++;
          $display("FAIL start_ignored: busy=%b wl=%0d required 1 11", busy, words_loaded);
        end
      end
    end
    wait_done();
    checks++;
    if (words_loaded !== 8'd64 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL full_final: wl=%0d cpu_rst=%b required 64 0", words_loaded, cpu_reset);
    end
    checks++;
    if (wq_addr.size() != 64) begin
      errors++;
      $display("FAIL full_write_count: %0d writes required 64", wq_addr.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 64; k++) begin
        w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        if (wq_addr[k] !== 32'(4*k) || wq_data[k] !== w) bad++;
      end
      if (bad != 0 || wq_addr[63] !== 32'hFC) begin
        errors++;
        $display("FAIL full_write_log: %0d bad entries, last addr %h required 0 and fc", bad, wq_addr[63]);
      end
    end
  endtask

  task automatic test_reset_midword();
    clear_writes();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({in_ready, mem_we, cpu_reset, busy, done, error} !== 6'b0 ||
        mem_addr !== 32'h0 || mem_wd !== 32'h0 || words_loaded !== 8'h0) begin
      errors++;
      $display("FAIL midword_reset: rdy=%b we=%b cpu_rst=%b busy=%b done=%b err=%b addr=%h wd=%h wl=%0d required all 0",
               in_ready, mem_we, cpu_reset, busy, done, error, mem_addr, mem_wd, words_loaded);
    end
    pulse_start();
    send_byte(8'h01, 0);
    send_word(32'h44332211, 32'h0, 0);
    wait_done();
    checks++;
    if (wq_addr.size() != 1 || wq_addr[0] !== 32'h0 || wq_data[0] !== 32'h44332211) begin
      errors++;
      $display("FAIL reload_after_reset: %0d writes, first %h@%h required 1 write 44332211@0",
               wq_addr.size(), (wq_data.size() > 0) ? wq_data[0] : 32'h0, (wq_addr.size() > 0) ? wq_addr[0] : 32'h0);
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_basic_load(0, "basic");
    test_basic_load(3, "stall");
    test_bad_header();
    test_full_depth();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
